// File: rtl/uart_receiver.sv
`default_nettype none
// uart_receiver: 8N1 serial receive engine feeding a show-ahead FIFO, with sticky framing/overrun flags.
// Revision 1.0 - initial release.
module uart_receiver #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun_err,
  input  logic                          err_clr
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
  localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  logic          sync1;
  logic          rxs;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          push;
  logic          ferr_set;

  // Both stages reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_MID) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          state_nxt = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rxs, shreg[7:1]};
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rxs) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_nxt = '0;
        if (rxs) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [NW-1:0] count;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          ovr_set;

  assign full     = (count == CNT_FULL);
  assign rx_valid = (count != '0);
  assign do_pop   = rx_valid && rx_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign do_push  = push && (!full || do_pop);
  assign ovr_set  = push && full && !do_pop;
  assign rx_count = count;
  assign rx_data  = rx_valid ? mem[rptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= ferr_set | (frame_err & ~err_clr);
      overrun_err <= ovr_set  | (overrun_err & ~err_clr);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// tb_uart_receiver: drives serial frames into uart_receiver and checks FIFO output against a byte scoreboard.
// Revision 1.0 - initial release.
module tb_uart_receiver;

  localparam int CLK_FREQ = 12_000_000;
  localparam int BAUD     = 115200;
  localparam int DEPTH    = 16;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  // Edges from the raw start-bit drive to the stop-sample cycle (2-cycle sync + HALF + 9 bits).
  localparam int STOP_CYC = 2 + HALF + 9 * CPB;
  localparam int PUSH_LAT = STOP_CYC + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_count;
  logic       frame_err;
  logic       overrun_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    int         exp_count;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[3];

  always #5 clk = ~clk;

  uart_receiver #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_count   (rx_count),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .err_clr    (err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    if (stop_low > 0) begin
      uart_rx = 1'b0;
      tick(stop_low * CPB);
    end
    uart_rx = 1'b1;
    tick(CPB);
  endtask

  // Pops one entry per cycle, comparing each head against the scoreboard.
  task automatic drain(input int n);
    rx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic exp_v;
      exp_v = (sb.size() > 0);
      check("pop_valid", {31'd0, rx_valid}, {31'd0, exp_v});
      if (exp_v) check("pop_data", {24'd0, rx_data}, {24'd0, sb.pop_front()});
      tick(1);
    end
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},  {24'd0, rx_data},   32'h0);
    check({tag, "_valid"}, {31'd0, rx_valid},  32'h0);
    check({tag, "_count"}, {27'd0, rx_count},  32'h0);
    check({tag, "_ferr"},  {31'd0, frame_err}, 32'h0);
    check({tag, "_oerr"},  {31'd0, overrun_err}, 32'h0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'hA5, 0, 1, 1'b0};
    vecs[1] = '{8'h3C, 0, 2, 1'b0};
    vecs[2] = '{8'hFF, 0, 3, 1'b0};

    tick(3);
    check_reset_vals("rst");
    reset = 1'b1;
    tick(3);

    // Single byte with exact push latency.
    sb.push_back(8'h55);
    fork
      send_frame(8'h55, 0);
      begin
        int n;
        n = 0;
        while (!rx_valid && n < PUSH_LAT + 50) begin
          tick(1);
          n++;
        end
        check("latency", n, PUSH_LAT);
      end
    join
    check("t1_count", {27'd0, rx_count}, 32'd1);
    check("t1_ferr", {31'd0, frame_err}, 32'd0);
    check("t1_oerr", {31'd0, overrun_err}, 32'd0);
    check("t1_data", {24'd0, rx_data}, 32'h55);
    drain(1);
    check("t1_valid_after", {31'd0, rx_valid}, 32'd0);
    check("t1_count_after", {27'd0, rx_count}, 32'd0);

    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("empty_pop_count", {27'd0, rx_count}, 32'd0);

    // Back-to-back frames from the table, consumer stalled.
    for (int i = 0; i < 3; i++) begin
      if (vecs[i].stop_low == 0) sb.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_low);
      check("tbl_count", {27'd0, rx_count}, vecs[i].exp_count);
      check("tbl_ferr", {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
    end
    drain(3);
    check("tbl_drained", {27'd0, rx_count}, 32'd0);

    // Short low glitch, then a frame starting just after the start check.
    uart_rx = 1'b0;
    tick(50);
    uart_rx = 1'b1;
    tick(HALF + 4 - 50);
    check("glitch_nopush", {31'd0, rx_valid}, 32'd0);
    sb.push_back(8'h12);
    send_frame(8'h12, 0);
    check("glitch_count", {27'd0, rx_count}, 32'd1);
    drain(1);

    // Framing error with a 2-bit-time low stop, then recovery.
    send_frame(8'h41, 2);
    check("ferr_set", {31'd0, frame_err}, 32'd1);
    check("ferr_count", {27'd0, rx_count}, 32'd0);
    sb.push_back(8'h42);
    send_frame(8'h42, 0);
    check("ferr_next_count", {27'd0, rx_count}, 32'd1);
    check("ferr_next_data", {24'd0, rx_data}, 32'h42);
    check("ferr_sticky", {31'd0, frame_err}, 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("ferr_clr", {31'd0, frame_err}, 32'd0);
    drain(1);

    // Fill the FIFO, then overrun with err_clr in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back(8'(i));
      send_frame(8'(i), 0);
    end
    check("full_count", {27'd0, rx_count}, DEPTH);
    fork
      send_frame(8'h99, 0);
      begin
        tick(STOP_CYC);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
      end
    join
    check("ovr_set", {31'd0, overrun_err}, 32'd1);
    check("ovr_count", {27'd0, rx_count}, DEPTH);
    check("ovr_head", {24'd0, rx_data}, 32'h00);

    // Pop exactly in the push cycle of 0xAA while full.
    sb.push_back(8'hAA);
    fork
      send_frame(8'hAA, 0);
      begin
        tick(STOP_CYC);
        check("pp_count_pre", {27'd0, rx_count}, DEPTH);
        check("pp_head_pre", {24'd0, rx_data}, {24'd0, sb.pop_front()});
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    check("pp_count", {27'd0, rx_count}, DEPTH);
    check("pp_head", {24'd0, rx_data}, 32'h01);
    check("pp_oerr_sticky", {31'd0, overrun_err}, 32'd1);
    drain(DEPTH);
    check("pp_drained", {27'd0, rx_count}, 32'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("oerr_clr", {31'd0, overrun_err}, 32'd0);

    // Reset in the middle of data bit 4 with a byte queued and frame_err set.
    send_frame(8'h77, 0);
    send_frame(8'h41, 1);
    check("pre_rst_count", {27'd0, rx_count}, 32'd1);
    check("pre_rst_ferr", {31'd0, frame_err}, 32'd1);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx = 8'hC3 >> i;
      tick(CPB);
    end
    uart_rx = 1'b0;
    tick(CPB / 2);
    #2 reset = 1'b0;
    #1 check_reset_vals("async_rst");
    uart_rx = 1'b1;
    tick(3);
    reset = 1'b1;
    sb.delete();
    tick(5);
    check_reset_vals("post_rst");
    sb.push_back(8'hC3);
    send_frame(8'hC3, 0);
    check("c3_count", {27'd0, rx_count}, 32'd1);
    check("c3_ferr", {31'd0, frame_err}, 32'd0);
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
